// File: rtl/trap_seq_pkg.sv
// Shared CSR defines for the trap sequencer: CSR addresses, cause codes,
// mstatus field positions, sequencer state encoding and mstatus rewrite helpers.
package trap_seq_pkg;

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MIE     = 12'h304;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
   localparam logic [11:0] ADDR_MIP     = 12'h344;

   localparam logic [63:0] CAUSE_MTIMER = 64'h8000_0000_0000_0007;
   localparam logic [63:0] CAUSE_ECALL  = 64'd11;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_W_MEPC    = 3'd1,
      ST_W_MCAUSE  = 3'd2,
      ST_W_MSTATUS = 3'd3,
      ST_R_MSTATUS = 3'd4,
      ST_REDIRECT  = 3'd5
   } trap_state_e;

   // Trap entry: stash MIE into MPIE, disable interrupts, record M-mode as previous.
   function automatic logic [63:0] trap_entry_mstatus(input logic [63:0] m);
      logic [63:0] r;
      r = m;
      r[MSTATUS_MPIE] = m[MSTATUS_MIE];
      r[MSTATUS_MIE]  = 1'b0;
      r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      return r;
   endfunction

   // MRET: restore MIE from MPIE, set MPIE, previous mode stays M.
   function automatic logic [63:0] mret_mstatus(input logic [63:0] m);
      logic [63:0] r;
      r = m;
      r[MSTATUS_MIE]  = m[MSTATUS_MPIE];
      r[MSTATUS_MPIE] = 1'b1;
      r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      return r;
   endfunction

endpackage

// File: rtl/trap_seq.sv
// Machine-mode trap/MRET sequencer: accepts a timer interrupt, ECALL or MRET at
// retire, writes MEPC/MCAUSE/MSTATUS through the CSR file's side port, then redirects fetch.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | waiting for a retiring event; only state where one is accepted
// ST_W_MEPC    | writing latched PC (word aligned) to MEPC
// ST_W_MCAUSE  | writing latched cause to MCAUSE
// ST_W_MSTATUS | writing trap-entry MSTATUS
// ST_R_MSTATUS | writing MRET-return MSTATUS
// ST_REDIRECT  | one-cycle fetch redirect to mtvec (trap) or mepc (mret)
module trap_seq
   import trap_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid_i,
   input  logic [63:0] pc_i,
   input  logic        ecall_i,
   input  logic        mret_i,
   input  logic        global_int_en_i,
   input  logic        mtime_int_en_i,
   input  logic        mtime_int_pend_i,
   input  logic [63:0] mtvec_i,
   input  logic [63:0] mepc_i,
   input  logic [63:0] mstatus_i,
   input  logic        cpu_csr_wen_i,
   output logic        csr_wen_o,
   output logic [11:0] csr_waddr_o,
   output logic [63:0] csr_wdata_o,
   output logic        trap_take_o,
   output logic        busy_o,
   output logic        redirect_valid_o,
   output logic [63:0] redirect_pc_o
);

   trap_state_e state_q, state_d;

   logic [63:0] pc_q;
   logic [63:0] cause_q;
   logic [63:0] mstatus_q;
   logic        is_mret_q;

   logic        int_req;
   logic        accept_int;
   logic        accept_ecall;
   logic        accept_mret;
   logic        accept;
   logic [63:0] cause_d;

   // Direct mode only; the vector mode bits are ignored.
   logic unused_mtvec_mode;
   assign unused_mtvec_mode = ^mtvec_i[1:0];

   always_comb begin
      int_req      = global_int_en_i & mtime_int_en_i & mtime_int_pend_i;
      accept_int   = 1'b0;
      accept_ecall = 1'b0;
      accept_mret  = 1'b0;
      if ((state_q == ST_IDLE) && instr_valid_i && !rst) begin
         if (int_req) begin
            accept_int = 1'b1;
         end else if (ecall_i) begin
            accept_ecall = 1'b1;
         end else if (mret_i) begin
            accept_mret = 1'b1;
         end
      end
      accept  = accept_int | accept_ecall | accept_mret;
      cause_d = accept_int ? CAUSE_MTIMER : (accept_ecall ? CAUSE_ECALL : 64'd0);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_mret) begin
               state_d = ST_R_MSTATUS;
            end else if (accept) begin
               state_d = ST_W_MEPC;
            end
         end
         ST_W_MEPC:    if (!cpu_csr_wen_i) state_d = ST_W_MCAUSE;
         ST_W_MCAUSE:  if (!cpu_csr_wen_i) state_d = ST_W_MSTATUS;
         ST_W_MSTATUS: if (!cpu_csr_wen_i) state_d = ST_REDIRECT;
         ST_R_MSTATUS: if (!cpu_csr_wen_i) state_d = ST_REDIRECT;
         ST_REDIRECT:  state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pc_q      <= '0;
         cause_q   <= '0;
         mstatus_q <= '0;
         is_mret_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            pc_q      <= pc_i;
            cause_q   <= cause_d;
            mstatus_q <= mstatus_i;
            is_mret_q <= accept_mret;
         end
      end
   end

   // Outputs decode from registered state only, so a held write repeats unchanged.
   always_comb begin
      csr_wen_o        = 1'b0;
      csr_waddr_o      = '0;
      csr_wdata_o      = '0;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = '0;
      trap_take_o      = accept;
      busy_o           = (state_q != ST_IDLE);
      case (state_q)
         ST_W_MEPC: begin
            csr_wen_o   = 1'b1;
            csr_waddr_o = ADDR_MEPC;
            csr_wdata_o = {pc_q[63:2], 2'b00};
         end
         ST_W_MCAUSE: begin
            csr_wen_o   = 1'b1;
            csr_waddr_o = ADDR_MCAUSE;
            csr_wdata_o = cause_q;
         end
         ST_W_MSTATUS: begin
            csr_wen_o   = 1'b1;
            csr_waddr_o = ADDR_MSTATUS;
            csr_wdata_o = trap_entry_mstatus(mstatus_q);
         end
         ST_R_MSTATUS: begin
            csr_wen_o   = 1'b1;
            csr_waddr_o = ADDR_MSTATUS;
            csr_wdata_o = mret_mstatus(mstatus_q);
         end
         ST_REDIRECT: begin
            redirect_valid_o = 1'b1;
            redirect_pc_o    = is_mret_q ? mepc_i : {mtvec_i[63:2], 2'b00};
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_trap_seq.sv
// Directed self-checking bench for trap_seq: trap/ecall/mret sequences,
// priority, busy masking, CPU write contention and mid-sequence reset.
module tb_trap_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid_i = 1'b0;
   logic [63:0] pc_i = '0;
   logic        ecall_i = 1'b0;
   logic        mret_i = 1'b0;
   logic        global_int_en_i = 1'b0;
   logic        mtime_int_en_i = 1'b0;
   logic        mtime_int_pend_i = 1'b0;
   logic [63:0] mtvec_i = '0;
   logic [63:0] mepc_i = '0;
   logic [63:0] mstatus_i = '0;
   logic        cpu_csr_wen_i = 1'b0;
   logic        csr_wen_o;
   logic [11:0] csr_waddr_o;
   logic [63:0] csr_wdata_o;
   logic        trap_take_o;
   logic        busy_o;
   logic        redirect_valid_o;
   logic [63:0] redirect_pc_o;

   int total = 0;
   int bad   = 0;

   logic [76:0]  csr_vec;
   logic [64:0]  rd_vec;
   logic [143:0] all_vec;
   assign csr_vec = {csr_wen_o, csr_waddr_o, csr_wdata_o};
   assign rd_vec  = {redirect_valid_o, redirect_pc_o};
   assign all_vec = {trap_take_o, busy_o, csr_vec, rd_vec};

   always #5 clk = ~clk;

   trap_seq dut (
      .clk              (clk),
      .rst              (rst),
      .instr_valid_i    (instr_valid_i),
      .pc_i             (pc_i),
      .ecall_i          (ecall_i),
      .mret_i           (mret_i),
      .global_int_en_i  (global_int_en_i),
      .mtime_int_en_i   (mtime_int_en_i),
      .mtime_int_pend_i (mtime_int_pend_i),
      .mtvec_i          (mtvec_i),
      .mepc_i           (mepc_i),
      .mstatus_i        (mstatus_i),
      .cpu_csr_wen_i    (cpu_csr_wen_i),
      .csr_wen_o        (csr_wen_o),
      .csr_waddr_o      (csr_waddr_o),
      .csr_wdata_o      (csr_wdata_o),
      .trap_take_o      (trap_take_o),
      .busy_o           (busy_o),
      .redirect_valid_o (redirect_valid_o),
      .redirect_pc_o    (redirect_pc_o)
   );

   // Lands 1 time unit after a rising edge; callers set inputs then wait #1 to sample.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet_inputs();
      instr_valid_i    = 1'b0;
      ecall_i          = 1'b0;
      mret_i           = 1'b0;
      mtime_int_pend_i = 1'b0;
      cpu_csr_wen_i    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      quiet_inputs();
      repeat (2) step();
      #1;
      total++;
      if (all_vec !== '0) begin
         bad++; $display("FAIL reset_outputs got=%h exp=0", all_vec);
      end
      rst = 1'b0;
      step();
      #1;
      total++;
      if (all_vec !== '0) begin
         bad++; $display("FAIL post_reset_idle got=%h exp=0", all_vec);
      end
   endtask

   task automatic test_timer_int();
      step();
      instr_valid_i = 1'b1; pc_i = 64'h8000_0010;
      global_int_en_i = 1'b1; mtime_int_en_i = 1'b1; mtime_int_pend_i = 1'b1;
      mstatus_i = 64'h1888; mtvec_i = 64'h8000_0101;
      #1;
      total++;
      if ({trap_take_o, busy_o, csr_wen_o} !== 3'b100) begin
         bad++; $display("FAIL tmr_accept got=%b exp=100", {trap_take_o, busy_o, csr_wen_o});
      end
      step();
      // Interrupt drops and CSR inputs change: sequence must continue from latched values.
      quiet_inputs(); mstatus_i = 64'hFFFF; pc_i = 64'h1234;
      #1;
      total++;
      if ({busy_o, csr_vec} !== {1'b1, 1'b1, 12'h341, 64'h8000_0010}) begin
         bad++; $display("FAIL tmr_mepc got=%h exp=%h", {busy_o, csr_vec}, {1'b1, 1'b1, 12'h341, 64'h8000_0010});
      end
      step(); #1;
      total++;
      if (csr_vec !== {1'b1, 12'h342, 64'h8000_0000_0000_0007}) begin
         bad++; $display("FAIL tmr_mcause got=%h exp=%h", csr_vec, {1'b1, 12'h342, 64'h8000_0000_0000_0007});
      end
      step(); #1;
      total++;
      if (csr_vec !== {1'b1, 12'h300, 64'h1880}) begin
         bad++; $display("FAIL tmr_mstatus got=%h exp=%h", csr_vec, {1'b1, 12'h300, 64'h1880});
      end
      step(); #1;
      total++;
      if ({rd_vec, csr_vec} !== {1'b1, 64'h8000_0100, 77'd0}) begin
         bad++; $display("FAIL tmr_redirect got=%h exp=%h", {rd_vec, csr_vec}, {1'b1, 64'h8000_0100, 77'd0});
      end
      step(); #1;
      total++;
      if (all_vec !== '0) begin
         bad++; $display("FAIL tmr_back_idle got=%h exp=0", all_vec);
      end
   endtask

   task automatic test_ecall_mret();
      step();
      instr_valid_i = 1'b1; ecall_i = 1'b1; pc_i = 64'h8000_0040;
      global_int_en_i = 1'b0; mtime_int_en_i = 1'b1; mtime_int_pend_i = 1'b1;
      mstatus_i = 64'h1880; mtvec_i = 64'h8000_0101;
      #1;
      total++;
      if (trap_take_o !== 1'b1) begin
         bad++; $display("FAIL ecall_accept got=%b exp=1", trap_take_o);
      end
      step(); quiet_inputs(); #1;
      total++;
      if (csr_vec !== {1'b1, 12'h341, 64'h8000_0040}) begin
         bad++; $display("FAIL ecall_mepc got=%h exp=%h", csr_vec, {1'b1, 12'h341, 64'h8000_0040});
      end
      step(); #1;
      total++;
      if (csr_vec !== {1'b1, 12'h342, 64'd11}) begin
         bad++; $display("FAIL ecall_mcause got=%h exp=%h", csr_vec, {1'b1, 12'h342, 64'd11});
      end
      step(); #1;
      total++;
      if (csr_vec !== {1'b1, 12'h300, 64'h1800}) begin
         bad++; $display("FAIL ecall_mstatus got=%h exp=%h", csr_vec, {1'b1, 12'h300, 64'h1800});
      end
      step(); #1;
      total++;
      if (rd_vec !== {1'b1, 64'h8000_0100}) begin
         bad++; $display("FAIL ecall_redirect got=%h exp=%h", rd_vec, {1'b1, 64'h8000_0100});
      end
      step();
      instr_valid_i = 1'b1; mret_i = 1'b1; mepc_i = 64'h8000_0044; mstatus_i = 64'h1880;
      #1;
      total++;
      if ({trap_take_o, busy_o} !== 2'b10) begin
         bad++; $display("FAIL mret_accept got=%b exp=10", {trap_take_o, busy_o});
      end
      step(); quiet_inputs(); #1;
      total++;
      if (csr_vec !== {1'b1, 12'h300, 64'h1888}) begin
         bad++; $display("FAIL mret_mstatus got=%h exp=%h", csr_vec, {1'b1, 12'h300, 64'h1888});
      end
      step(); #1;
      total++;
      if ({rd_vec, csr_wen_o} !== {1'b1, 64'h8000_0044, 1'b0}) begin
         bad++; $display("FAIL mret_redirect got=%h exp=%h", {rd_vec, csr_wen_o}, {1'b1, 64'h8000_0044, 1'b0});
      end
      step(); #1;
      total++;
      if ({busy_o, redirect_valid_o} !== 2'b00) begin
         bad++; $display("FAIL mret_back_idle got=%b exp=00", {busy_o, redirect_valid_o});
      end
   endtask

   task automatic test_priority_busy();
      step();
      instr_valid_i = 1'b0; global_int_en_i = 1'b1; mtime_int_en_i = 1'b1; mtime_int_pend_i = 1'b1;
      #1;
      total++;
      if ({trap_take_o, busy_o} !== 2'b00) begin
         bad++; $display("FAIL no_valid_no_take got=%b exp=00", {trap_take_o, busy_o});
      end
      step();
      instr_valid_i = 1'b1; ecall_i = 1'b1; mret_i = 1'b1; pc_i = 64'h8000_0207; mstatus_i = 64'h0008;
      #1;
      total++;
      if (trap_take_o !== 1'b1) begin
         bad++; $display("FAIL prio_accept got=%b exp=1", trap_take_o);
      end
      // Events stay asserted through the whole sequence and must be ignored.
      step(); #1;
      total++;
      if ({trap_take_o, csr_vec} !== {1'b0, 1'b1, 12'h341, 64'h8000_0204}) begin
         bad++; $display("FAIL prio_mepc_align got=%h exp=%h", {trap_take_o, csr_vec}, {1'b0, 1'b1, 12'h341, 64'h8000_0204});
      end
      step(); #1;
      total++;
      if ({trap_take_o, csr_vec} !== {1'b0, 1'b1, 12'h342, 64'h8000_0000_0000_0007}) begin
         bad++; $display("FAIL prio_int_cause got=%h exp=%h", {trap_take_o, csr_vec}, {1'b0, 1'b1, 12'h342, 64'h8000_0000_0000_0007});
      end
      step(); #1;
      total++;
      if ({trap_take_o, csr_vec} !== {1'b0, 1'b1, 12'h300, 64'h1880}) begin
         bad++; $display("FAIL prio_mstatus got=%h exp=%h", {trap_take_o, csr_vec}, {1'b0, 1'b1, 12'h300, 64'h1880});
      end
      step(); #1;
      total++;
      if ({trap_take_o, rd_vec} !== {1'b0, 1'b1, 64'h8000_0100}) begin
         bad++; $display("FAIL prio_redirect got=%h exp=%h", {trap_take_o, rd_vec}, {1'b0, 1'b1, 64'h8000_0100});
      end
      quiet_inputs();
      step();
      // ECALL beats MRET when no interrupt is pending.
      instr_valid_i = 1'b1; ecall_i = 1'b1; mret_i = 1'b1; global_int_en_i = 1'b0; pc_i = 64'h8000_0300;
      step(); quiet_inputs(); #1;
      total++;
      if (csr_vec !== {1'b1, 12'h341, 64'h8000_0300}) begin
         bad++; $display("FAIL ecall_over_mret got=%h exp=%h", csr_vec, {1'b1, 12'h341, 64'h8000_0300});
      end
      repeat (4) step();
   endtask

   task automatic test_contention();
      step();
      instr_valid_i = 1'b1; pc_i = 64'h8000_0010; mstatus_i = 64'h1888;
      global_int_en_i = 1'b1; mtime_int_en_i = 1'b1; mtime_int_pend_i = 1'b1;
      step(); quiet_inputs(); #1;
      total++;
      if (csr_vec !== {1'b1, 12'h341, 64'h8000_0010}) begin
         bad++; $display("FAIL cont_mepc got=%h exp=%h", csr_vec, {1'b1, 12'h341, 64'h8000_0010});
      end
      step(); cpu_csr_wen_i = 1'b1; #1;
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({csr_vec, redirect_valid_o} !== {1'b1, 12'h342, 64'h8000_0000_0000_0007, 1'b0}) begin
            bad++; $display("FAIL cont_mcause_hold%0d got=%h exp=%h", i, csr_vec, {1'b1, 12'h342, 64'h8000_0000_0000_0007});
         end
         step();
         cpu_csr_wen_i = (i == 0);
         #1;
      end
      total++;
      if (csr_vec !== {1'b1, 12'h300, 64'h1880}) begin
         bad++; $display("FAIL cont_mstatus got=%h exp=%h", csr_vec, {1'b1, 12'h300, 64'h1880});
      end
      step(); #1;
      total++;
      if (rd_vec !== {1'b1, 64'h8000_0100}) begin
         bad++; $display("FAIL cont_redirect_t6 got=%h exp=%h", rd_vec, {1'b1, 64'h8000_0100});
      end
      step(); #1;
      total++;
      if (busy_o !== 1'b0) begin
         bad++; $display("FAIL cont_back_idle got=%b exp=0", busy_o);
      end
   endtask

   task automatic test_reset_mid();
      step();
      instr_valid_i = 1'b1; pc_i = 64'h8000_0010; mstatus_i = 64'h1888;
      global_int_en_i = 1'b1; mtime_int_en_i = 1'b1; mtime_int_pend_i = 1'b1;
      step(); quiet_inputs();
      step(); #1;
      total++;
      if (csr_waddr_o !== 12'h342) begin
         bad++; $display("FAIL rstmid_in_mcause got=%h exp=342", csr_waddr_o);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (all_vec !== '0) begin
            bad++; $display("FAIL rstmid_quiet%0d got=%h exp=0", i, all_vec);
         end
         step();
         #1;
      end
   endtask

   initial begin
      test_reset();
      test_timer_int();
      test_ecall_mret();
      test_priority_busy();
      test_contention();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
